// File: rtl/viterbi_pkg.sv
// Shared constants for the convolutional encoder/framer and the Viterbi decoder:
// code generators, frame widths, framer state encoding and the branch-output helper.
package viterbi_pkg;

    localparam int K      = 3;
    localparam int MSG_W  = 8;
    localparam int CODE_W = 16;

    // Generator taps ordered {u, s1, s2}; the decoder BMUs use the same pair.
    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Encoder output pair {g0,g1} for input bit u and state (s1,s2).
    function automatic logic [1:0] conv_pair(input logic u, input logic s1, input logic s2);
        logic [2:0] win;
        win = {u, s1, s2};
        return {^(win & G0), ^(win & G1)};
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Rate-1/2, K=3 encoder core: combinational output pair plus the two-stage
// state register, which can be cleared synchronously at a frame start.
module conv_enc_core
    import viterbi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       u,
    output logic [1:0] pair
);

    logic s1_r;
    logic s2_r;

    assign pair = conv_pair(u, s1_r, s2_r);

    // Encoder state shift; a clear wins over a shift so every frame starts in state 00.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else if (clr) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else if (en) begin
            s2_r <= s1_r;
            s1_r <= u;
        end else begin
            s1_r <= s1_r;
            s2_r <= s2_r;
        end
    end

endmodule

// File: rtl/conv_encoder_framer.sv
// Framer feeding the Viterbi decoder: accepts one message byte, encodes it
// MSB-first into a 16-bit codeword (pair 0 in bits [15:14]), optionally XORs an
// error pattern in, and holds the word until the consumer takes it.
module conv_encoder_framer
    import viterbi_pkg::*;
#(
    parameter bit ERR_INJ_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MSG_W-1:0]  msg_in,
    input  logic              msg_valid,
    output logic              msg_ready,
    input  logic [CODE_W-1:0] err_mask,
    output logic [CODE_W-1:0] code_out,
    output logic              code_valid,
    input  logic              code_ready,
    output logic [7:0]        frame_cnt
);

    state_t            state_r;
    state_t            state_n;
    logic [MSG_W-1:0]  msg_r;
    logic [CODE_W-1:0] mask_r;
    logic [2:0]        cnt_r;
    logic [CODE_W-1:0] code_r;
    logic [CODE_W-1:0] code_n;
    logic              code_valid_r;
    logic [7:0]        frame_cnt_r;

    logic              msg_ready_s;
    logic              accept_s;
    logic              deliver_s;
    logic              enc_en_s;
    logic              last_s;
    logic [1:0]        pair_s;
    logic [3:0]        hi_s;

    conv_enc_core u_core (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept_s),
        .en   (enc_en_s),
        .u    (msg_r[MSG_W-1]),
        .pair (pair_s)
    );

    // Frame sequencing and handshake decode; HOLD can hand off and accept on one edge.
    always_comb begin
        state_n     = state_r;
        msg_ready_s = 1'b0;
        accept_s    = 1'b0;
        deliver_s   = 1'b0;
        enc_en_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                msg_ready_s = 1'b1;
                if (msg_valid) begin
                    accept_s = 1'b1;
                    state_n  = ENCODE;
                end else begin
                    state_n  = IDLE;
                end
            end
            ENCODE: begin
                enc_en_s = 1'b1;
                if (cnt_r == 3'd7) begin
                    last_s  = 1'b1;
                    state_n = HOLD;
                end else begin
                    state_n = ENCODE;
                end
            end
            HOLD: begin
                if (code_ready) begin
                    msg_ready_s = 1'b1;
                    deliver_s   = 1'b1;
                    if (msg_valid) begin
                        accept_s = 1'b1;
                        state_n  = ENCODE;
                    end else begin
                        state_n  = IDLE;
                    end
                end else begin
                    state_n = HOLD;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Drop the current pair into its slot; the error pattern is applied with the last pair.
    always_comb begin
        code_n = code_r;
        hi_s   = 4'd15 - {cnt_r, 1'b0};
        if (enc_en_s) begin
            code_n[hi_s -: 2] = pair_s;
            if (last_s && ERR_INJ_EN) begin
                code_n = code_n ^ mask_r;
            end else begin
                code_n = code_n;
            end
        end else begin
            code_n = code_r;
        end
    end

    // Framer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Message/mask capture, bit counter and codeword assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_r  <= 8'h00;
            mask_r <= 16'h0000;
            cnt_r  <= 3'd0;
            code_r <= 16'h0000;
        end else begin
            code_r <= code_n;
            if (accept_s) begin
                msg_r  <= msg_in;
                mask_r <= err_mask;
                cnt_r  <= 3'd0;
            end else if (enc_en_s) begin
                msg_r  <= {msg_r[MSG_W-2:0], 1'b0};
                cnt_r  <= cnt_r + 3'd1;
            end else begin
                msg_r  <= msg_r;
                cnt_r  <= cnt_r;
            end
        end
    end

    // Output valid flag and delivered-frame counter (wraps naturally at 8 bits).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_valid_r <= 1'b0;
            frame_cnt_r  <= 8'd0;
        end else begin
            if (last_s) begin
                code_valid_r <= 1'b1;
            end else if (deliver_s) begin
                code_valid_r <= 1'b0;
            end else begin
                code_valid_r <= code_valid_r;
            end
            if (deliver_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign msg_ready  = msg_ready_s;
    assign code_out   = code_r;
    assign code_valid = code_valid_r;
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Directed bench for conv_encoder_framer: hand-computed codewords, latency,
// backpressure, same-edge handoff, mid-frame reset and a 256-frame stream.
module tb_conv_encoder_framer;

    logic        clk;
    logic        rst;
    logic [7:0]  msg_in;
    logic        msg_valid;
    logic [15:0] err_mask;
    logic        code_ready;

    logic        msg_ready;
    logic [15:0] code_out;
    logic        code_valid;
    logic [7:0]  frame_cnt;

    logic        msg_ready_n;
    logic [15:0] code_out_n;
    logic        code_valid_n;
    logic [7:0]  frame_cnt_n;

    int vectors;
    int miscompares;
    int exp_fc;

    conv_encoder_framer #(.ERR_INJ_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .msg_in     (msg_in),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .err_mask   (err_mask),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .frame_cnt  (frame_cnt)
    );

    conv_encoder_framer #(.ERR_INJ_EN(1'b0)) dut_noinj (
        .clk        (clk),
        .rst        (rst),
        .msg_in     (msg_in),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready_n),
        .err_mask   (err_mask),
        .code_out   (code_out_n),
        .code_valid (code_valid_n),
        .code_ready (code_ready),
        .frame_cnt  (frame_cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent reference: pair k = {u^s1^s2, u^s2} placed at [15-2k:14-2k].
    function automatic logic [15:0] ref_enc(input logic [7:0] m);
        logic [15:0] r;
        logic a;
        logic b;
        logic u;
        r = 16'h0000;
        a = 1'b0;
        b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            u = m[7-i];
            r[15-2*i] = u ^ a ^ b;
            r[14-2*i] = u ^ b;
            b = a;
            a = u;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer a byte, wait for it to be taken, then count edges until code_valid.
    task automatic send_and_wait(input logic [7:0] b, input logic [15:0] m);
        int n;
        msg_in    = b;
        err_mask  = m;
        msg_valid = 1'b1;
        n = 0;
        while (msg_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_seen", {31'd0, msg_ready}, 32'd1);
        @(negedge clk);
        msg_valid = 1'b0;
        n = 0;
        while (code_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("valid_latency_edges", n, 32'd8);
    endtask

    task automatic deliver();
        code_ready = 1'b1;
        @(negedge clk);
        code_ready = 1'b0;
        exp_fc = (exp_fc + 1) % 256;
        chk("valid_drop", {31'd0, code_valid}, 32'd0);
        chk("frame_cnt", {24'd0, frame_cnt}, exp_fc);
    endtask

    initial begin
        logic [7:0] b;
        int n;
        vectors     = 0;
        miscompares = 0;
        exp_fc      = 0;
        rst         = 1'b0;
        msg_in      = 8'h00;
        msg_valid   = 1'b0;
        err_mask    = 16'h0000;
        code_ready  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_code_out", {16'd0, code_out}, 32'h0);
        chk("rst_code_valid", {31'd0, code_valid}, 32'd0);
        chk("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        chk("rst_msg_ready", {31'd0, msg_ready}, 32'd1);
        chk("rst_msg_ready_noinj", {31'd0, msg_ready_n}, 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Basic codewords
        send_and_wait(8'h00, 16'h0000);
        chk("code_00", {16'd0, code_out}, 32'h0000);
        deliver();
        send_and_wait(8'h80, 16'h0000);
        chk("code_80", {16'd0, code_out}, 32'hEC00);
        deliver();
        send_and_wait(8'hFF, 16'h0000);
        chk("code_FF", {16'd0, code_out}, 32'hDAAA);
        deliver();

        // Error injection enabled vs disabled
        send_and_wait(8'h80, 16'h0001);
        chk("code_80_inj", {16'd0, code_out}, 32'hEC01);
        chk("code_80_noinj", {16'd0, code_out_n}, 32'hEC00);
        deliver();

        // Backpressure for 20 cycles, then same-edge handoff with a new byte
        send_and_wait(8'h80, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_code_out", {16'd0, code_out}, 32'hEC00);
            chk("bp_msg_ready", {31'd0, msg_ready}, 32'd0);
            chk("bp_code_valid", {31'd0, code_valid}, 32'd1);
            chk("bp_frame_cnt", {24'd0, frame_cnt}, exp_fc);
        end
        code_ready = 1'b1;
        msg_valid  = 1'b1;
        msg_in     = 8'hFF;
        err_mask   = 16'h0000;
        #1;
        chk("handoff_msg_ready", {31'd0, msg_ready}, 32'd1);
        @(negedge clk);
        code_ready = 1'b0;
        msg_valid  = 1'b0;
        exp_fc = (exp_fc + 1) % 256;
        chk("handoff_valid_drop", {31'd0, code_valid}, 32'd0);
        chk("handoff_frame_cnt", {24'd0, frame_cnt}, exp_fc);
        n = 0;
        while (code_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("handoff_latency_edges", n, 32'd8);
        chk("handoff_code_FF", {16'd0, code_out}, 32'hDAAA);
        deliver();

        // Reset in the middle of ENCODE (after 4 bits)
        msg_in    = 8'h80;
        msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        exp_fc = 0;
        chk("midrst_code_valid", {31'd0, code_valid}, 32'd0);
        chk("midrst_code_out", {16'd0, code_out}, 32'h0);
        chk("midrst_msg_ready", {31'd0, msg_ready}, 32'd1);
        chk("midrst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_no_valid", {31'd0, code_valid}, 32'd0);
        send_and_wait(8'h80, 16'h0000);
        chk("post_rst_code_80", {16'd0, code_out}, 32'hEC00);
        deliver();

        // 256 frames back to back; busy-time msg_valid and code_ready are ignored
        err_mask   = 16'h0000;
        code_ready = 1'b1;
        msg_valid  = 1'b1;
        msg_in     = 8'd11;
        @(negedge clk);
        for (int f = 0; f < 256; f++) begin
            b = 8'((f * 37 + 11) % 256);
            repeat (7) @(negedge clk);
            chk("stream_not_yet_valid", {31'd0, code_valid}, 32'd0);
            @(negedge clk);
            chk("stream_valid", {31'd0, code_valid}, 32'd1);
            chk("stream_code", {16'd0, code_out}, {16'd0, ref_enc(b)});
            chk("stream_code_noinj", {16'd0, code_out_n}, {16'd0, ref_enc(b)});
            msg_in = 8'(((f + 1) * 37 + 11) % 256);
            if (f == 255) begin
                msg_valid = 1'b0;
            end
            @(negedge clk);
            exp_fc = (exp_fc + 1) % 256;
            chk("stream_frame_cnt", {24'd0, frame_cnt}, exp_fc);
        end
        code_ready = 1'b0;
        chk("stream_wrap_cnt", {24'd0, frame_cnt}, 32'd1);
        @(negedge clk);
        chk("stream_end_idle_ready", {31'd0, msg_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
